// File: rtl/operand_isolation_ctrl.sv
// -----------------------------------------------------------------------------
// operand_isolation_ctrl
//
// Sequences a downstream operand-isolated adder. Operand pairs are registered
// onto iso_a/iso_b and held there between operations, so the adder inputs only
// move when a new pair is accepted. The adder is enabled for exactly one cycle
// (ISSUE), its sum is captured and held (HOLD) until the consumer takes it.
// After IDLE_CYCLES idle cycles the block drops into SLEEP. Leaving SLEEP
// costs one cycle: the waking request is not accepted there.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     upstream operand pair valid
//   in_ready     block can accept an operand pair (0 while rst=1)
//   in_a, in_b   upstream operands
//   iso_enable   enable for the downstream adder, high only in ISSUE
//   iso_a, iso_b registered operands driven to the adder
//   iso_sum      sum returned combinationally by the adder
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_sum      captured result
//   sleep        block is in SLEEP
//   issue_count  number of issued operations, saturating at 0xFFFF
//
// Build option
//   OPISO_ISSUE_COUNT_EN  when defined, issue_count is a live saturating
//                         counter; otherwise it is tied to zero and no
//                         counter logic is built.
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for operands, counting idle cycles toward SLEEP
//   ST_ISSUE | adder enabled for one cycle, sum captured at its end
//   ST_HOLD  | result presented, waiting for out_ready
//   ST_SLEEP | low-activity state, in_valid wakes to IDLE
// -----------------------------------------------------------------------------
module operand_isolation_ctrl #(
   parameter int WIDTH       = 8,
   parameter int IDLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             iso_enable,
   output logic [WIDTH-1:0] iso_a,
   output logic [WIDTH-1:0] iso_b,
   input  logic [WIDTH-1:0] iso_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             sleep,
   output logic [15:0]      issue_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2,
      ST_SLEEP = 2'd3
   } state_t;

   localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_CYCLES);

   state_t     state, state_nxt;
   logic [7:0] idle_cnt, idle_cnt_nxt;
   logic       accept;

   always_comb begin
      state_nxt    = state;
      idle_cnt_nxt = idle_cnt;
      in_ready     = 1'b0;
      accept       = 1'b0;
      iso_enable   = 1'b0;
      out_valid    = 1'b0;
      sleep        = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept       = 1'b1;
               idle_cnt_nxt = '0;
               state_nxt    = ST_ISSUE;
            end else if (idle_cnt + 8'd1 == IDLE_LIMIT) begin
               idle_cnt_nxt = '0;
               state_nxt    = ST_SLEEP;
            end else begin
               idle_cnt_nxt = idle_cnt + 8'd1;
            end
         end
         ST_ISSUE: begin
            iso_enable = 1'b1;
            state_nxt  = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            // Consumer taking the result frees the operand slot in the same
            // cycle, which gives back-to-back issue without an IDLE bubble.
            if (out_ready) begin
               in_ready = 1'b1;
               if (in_valid) begin
                  accept       = 1'b1;
                  idle_cnt_nxt = '0;
                  state_nxt    = ST_ISSUE;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_SLEEP: begin
            sleep = 1'b1;
            if (in_valid) begin
               idle_cnt_nxt = '0;
               state_nxt    = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (rst) begin
         in_ready = 1'b0;
         accept   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         idle_cnt <= '0;
         iso_a    <= '0;
         iso_b    <= '0;
         out_sum  <= '0;
      end else begin
         state    <= state_nxt;
         idle_cnt <= idle_cnt_nxt;
         if (accept) begin
            iso_a <= in_a;
            iso_b <= in_b;
         end
         if (state == ST_ISSUE) begin
            out_sum <= iso_sum;
         end
      end
   end

`ifdef OPISO_ISSUE_COUNT_EN
   logic [15:0] issue_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cnt_q <= '0;
      end else if (state == ST_ISSUE && issue_cnt_q != 16'hFFFF) begin
         issue_cnt_q <= issue_cnt_q + 16'd1;
      end
   end

   assign issue_count = issue_cnt_q;
`else
   assign issue_count = '0;
`endif

endmodule

// File: doc/operand_isolation_ctrl.md
OPERAND_ISOLATION_CTRL -- requirements
Module: operand_isolation_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits.
REQ-002 Parameter IDLE_CYCLES, default 4: consecutive idle cycles in IDLE before entering SLEEP; legal range 1..255.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 in_a, in_b  input  WIDTH  upstream operands.
REQ-008 iso_enable  output  1  drives the enable of the downstream operand-isolated adder.
REQ-009 iso_a, iso_b  output  WIDTH  registered operands driven to the adder.
REQ-010 iso_sum  input  WIDTH  sum returned combinationally from the adder.
REQ-011 out_valid  output  1  result valid; out_ready  input  1  consumer accepts the result.
REQ-012 out_sum  output  WIDTH  captured result.
REQ-013 sleep  output  1  block is in SLEEP.
REQ-014 issue_count  output  16  number of issued operations (see Configuration).

Function
REQ-015 FSM states: IDLE, ISSUE, HOLD, SLEEP; encoding is implementation-defined.
REQ-016 IDLE: in_ready=1; on in_valid, latch in_a/in_b into iso_a/iso_b, clear the idle counter, go to ISSUE.
REQ-017 IDLE without in_valid: idle counter increments; when the counter reaches IDLE_CYCLES, go to SLEEP.
REQ-018 ISSUE lasts exactly one cycle: iso_enable=1, in_ready=0; at the end of the cycle, capture iso_sum into out_sum, set out_valid=1, go to HOLD.
REQ-019 iso_enable SHALL be 1 only in ISSUE; iso_a/iso_b SHALL hold their last values in every other state (no operand toggling).
REQ-020 HOLD: out_valid=1, out_sum stable; on out_ready, clear out_valid and go to IDLE.
REQ-021 HOLD with out_ready=1 and in_valid=1 in the same cycle: in_ready=1 in that cycle, operands accepted, next state ISSUE (zero-bubble back-to-back); out_valid=0 during that ISSUE.
REQ-022 Latency: accept at edge N -> iso_enable high in cycle N+1 -> out_valid high from edge N+2.
REQ-023 SLEEP: sleep=1, in_ready=0, iso_enable=0; in_valid=1 -> next state IDLE with counter cleared (one-cycle wake penalty, operands not accepted in SLEEP).
REQ-024 Arithmetic is the adder's: out_sum is iso_sum truncated to WIDTH, with wrap-around modulo 2^WIDTH and no carry output.
REQ-025 Inputs to in_a/in_b while in_ready=0 SHALL be ignored.

Reset
REQ-026 rst=1 at a clock edge forces: state IDLE, iso_enable=0, iso_a=iso_b=0, out_sum=0, out_valid=0, sleep=0, idle counter=0, issue_count=0.
REQ-027 rst in any state, including mid-ISSUE or HOLD, discards the pending result; no out_valid pulse follows.
REQ-028 in_ready is 0 while rst=1.

Configuration
REQ-029 Macro OPISO_ISSUE_COUNT_EN defined: issue_count increments by 1 on every ISSUE cycle and saturates at 0xFFFF.
REQ-030 Macro OPISO_ISSUE_COUNT_EN undefined: no counter logic; issue_count is tied to 0.

Verification
REQ-031 Accept a=0x0F, b=0xF0 with out_ready=1 -> iso_enable high for exactly 1 cycle, out_valid at N+2, out_sum=0xFF.
REQ-032 a=0xFF, b=0x01 -> out_sum=0x00 (wrap-around); then a=0xAA, b=0x55 back-to-back with out_ready held at 1 -> out_sum=0xFF with no idle bubble.
REQ-033 out_ready held at 0 for 5 cycles -> out_valid and out_sum stable, in_ready=0, iso_a/iso_b unchanged, iso_enable=0.
REQ-034 No in_valid for 4 cycles (default) -> sleep=1; then in_valid=1 -> in_ready=0 that cycle, IDLE next cycle, pair accepted one cycle later.
REQ-035 rst asserted during HOLD -> all outputs at reset values next edge, no out_valid afterwards; with OPISO_ISSUE_COUNT_EN defined, issue_count=3 after 3 ops, 0 after reset.
